// File: rtl/arb2_stream_nbit.sv
// Two-input round-robin arbiter with a registered output stage.
// The output carries the winning word (z) and the channel it came from (s).
module arb2_stream_nbit #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] x0,
  input  logic         x0_valid,
  output logic         x0_ready,
  input  logic [N-1:0] x1,
  input  logic         x1_valid,
  output logic         x1_ready,
  output logic [N-1:0] z,
  output logic         s,
  output logic         z_valid,
  input  logic         z_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state, state_nxt;
  logic   pri;
  logic   load_en;
  logic   gnt_vld;
  logic   gnt;
  logic   take;

  assign z_valid = (state == FULL);

  always_comb begin
    state_nxt = state;
    // A full register can refill on the same edge its word is consumed.
    load_en   = (state == EMPTY) | z_ready;
    gnt_vld   = x0_valid | x1_valid;
    gnt       = (x0_valid & x1_valid) ? pri : x1_valid;
    x0_ready  = load_en & gnt_vld & ~gnt;
    x1_ready  = load_en & gnt_vld & gnt;
    take      = x0_ready | x1_ready;
    if (take)
      state_nxt = FULL;
    else if (load_en)
      state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      z     <= '0;
      s     <= 1'b0;
      pri   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        z   <= gnt ? x1 : x0;
        s   <= gnt;
        pri <= ~gnt;
      end
    end
  end

endmodule

// File: tb/tb_arb2_stream_nbit.sv
// Bench for arb2_stream_nbit: directed scenarios then random traffic,
// all checked against a transaction-level model of the arbiter.
module tb_arb2_stream_nbit;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] x0, x1, z;
  logic         x0_valid, x1_valid, x0_ready, x1_ready;
  logic         s, z_valid, z_ready;

  int checks = 0;
  int errors = 0;

  // Model state: held word, its source, occupancy and favoured channel.
  logic [N-1:0] m_z;
  logic         m_s, m_v, m_pri;
  bit           m_init = 1'b0;

  arb2_stream_nbit #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .x0(x0), .x0_valid(x0_valid), .x0_ready(x0_ready),
    .x1(x1), .x1_valid(x1_valid), .x1_ready(x1_ready),
    .z(z), .s(s), .z_valid(z_valid), .z_ready(z_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check readies, clock, update model, check outputs.
  task automatic cycle(input logic r, input logic [N-1:0] a, input logic av,
                       input logic [N-1:0] b, input logic bv, input logic zr);
    bit space, has, g;
    rst_n = r; x0 = a; x0_valid = av; x1 = b; x1_valid = bv; z_ready = zr;
    #1;
    space = !m_v || zr;
    has   = av || bv;
    if (av && bv) g = m_pri;
    else          g = bv;
    if (m_init) begin
      chk("x0_ready", x0_ready, space && has && !g);
      chk("x1_ready", x1_ready, space && has && g);
    end
    @(posedge clk);
    if (!r) begin
      m_z = '0; m_s = 0; m_v = 0; m_pri = 0; m_init = 1'b1;
    end else if (m_init) begin
      if (space && has) begin
        m_z = g ? b : a; m_s = g; m_v = 1; m_pri = !g;
      end else if (space) begin
        m_v = 0;
      end
    end
    #1;
    if (m_init) begin
      chk("z_valid", z_valid, m_v);
      chk("z", z, m_z);
      chk("s", s, m_s);
    end
  endtask

  initial begin
    rst_n = 0; x0 = '0; x1 = '0; x0_valid = 0; x1_valid = 0; z_ready = 0;
    m_z = '0; m_s = 0; m_v = 0; m_pri = 0;

    // Reset dominates active inputs; first edge after release loads x0.
    cycle(0, 2'b01, 1, 2'b11, 1, 1);
    cycle(0, 2'b01, 1, 2'b11, 1, 1);
    chk("rst_z", z, 0);
    cycle(1, 2'b01, 1, 2'b11, 1, 1);
    chk("first_s", s, 0);

    // Single channel x1.
    cycle(0, 2'b00, 0, 2'b00, 0, 1);
    cycle(1, 2'b00, 0, 2'b10, 1, 1);
    chk("single_z", z, 2'b10);
    chk("single_s", s, 1);

    // Contention fairness after reset: 0,1,0,1.
    cycle(0, 2'b00, 0, 2'b00, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 2'b01, 1, 2'b11, 1, 1);
      chk("alt_s", s, i[0]);
    end

    // Backpressure: load x0 (pri becomes 1) then stall with both valid.
    cycle(0, 2'b00, 0, 2'b00, 0, 1);
    cycle(1, 2'b01, 1, 2'b11, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 2'b01, 1, 2'b11, 1, 0);
      chk("stall_z", z, 2'b01);
    end
    cycle(1, 2'b01, 1, 2'b11, 1, 1);
    chk("resume_z", z, 2'b11);
    chk("resume_s", s, 1);

    // Drain keeps z/s.
    cycle(1, 2'b00, 0, 2'b00, 0, 1);
    chk("drain_v", z_valid, 0);
    chk("drain_z", z, 2'b11);

    // Reset while full and stalled discards the word.
    cycle(1, 2'b10, 1, 2'b00, 0, 0);
    cycle(0, 2'b10, 1, 2'b00, 0, 0);
    chk("midrst_v", z_valid, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) != 0), N'($urandom), $urandom_range(0, 3) != 0,
            N'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
